// File: rtl/reg_8x64b_rd_arb_pkg.sv
// Shared constants and response-slot state encoding for the register-file read arbiter.
package reg_8x64b_rd_arb_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/reg_8x64b_rd_arb_rd_rsp_slot.sv
// One-entry response buffer for a single read client: EMPTY/FULL FSM, snapshot data
// register, and the eligibility signal the arbiter uses to decide whether a grant can land.
module reg_8x64b_rd_arb_rd_rsp_slot
  import reg_8x64b_rd_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  input  logic              i_rsp_ready,
  input  logic              i_grant,
  input  logic [DATA_W-1:0] i_cap_data,
  output logic              o_eligible,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_data,
  output slot_state_e       o_state
);

  slot_state_e       r_state;
  logic [DATA_W-1:0] r_data;

  // A full slot can still take a new grant when the client drains it in the same cycle.
  assign o_eligible  = i_req_valid && ((r_state == SLOT_EMPTY) || i_rsp_ready);
  assign o_rsp_valid = (r_state == SLOT_FULL);
  assign o_rsp_data  = r_data;
  assign o_state     = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else begin
      case (r_state)
        SLOT_EMPTY: begin
          if (i_grant) begin
            r_state <= SLOT_FULL;
            r_data  <= i_cap_data;
          end
        end
        SLOT_FULL: begin
          if (i_grant) begin
            r_state <= SLOT_FULL;
            r_data  <= i_cap_data;
          end else if (i_rsp_ready) begin
            r_state <= SLOT_EMPTY;
          end
        end
        default: r_state <= SLOT_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/reg_8x64b_rd_arb.sv
// Round-robin front end sharing the register file's single read port between two clients,
// with write-port snooping so a same-cycle write to the read entry is forwarded.
module reg_8x64b_rd_arb
  import reg_8x64b_rd_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_req_valid,
  input  logic [ADDR_W-1:0] c0_req_addr,
  output logic              c0_req_ready,
  output logic              c0_rsp_valid,
  output logic [DATA_W-1:0] c0_rsp_data,
  input  logic              c0_rsp_ready,
  input  logic              c1_req_valid,
  input  logic [ADDR_W-1:0] c1_req_addr,
  output logic              c1_req_ready,
  output logic              c1_rsp_valid,
  output logic [DATA_W-1:0] c1_rsp_data,
  input  logic              c1_rsp_ready,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  input  logic              rf_wr_en,
  input  logic [ADDR_W-1:0] rf_wr_addr,
  input  logic [DATA_W-1:0] rf_wr_data
);

  // Handshake: a request transfers when req_valid && req_ready; a response transfers when
  // rsp_valid && rsp_ready. Ungranted requests must be held stable by the client.

  logic              r_last_grant;
  logic              w_elig0;
  logic              w_elig1;
  logic              w_grant0;
  logic              w_grant1;
  logic [DATA_W-1:0] w_cap_data;
  slot_state_e       w_state0;
  slot_state_e       w_state1;

  // r_last_grant == 1 means client 1 was served last, so client 0 wins the next contention.
  assign w_grant0 = w_elig0 && (!w_elig1 || r_last_grant);
  assign w_grant1 = w_elig1 && (!w_elig0 || !r_last_grant);

  assign c0_req_ready = w_grant0;
  assign c1_req_ready = w_grant1;

  assign rf_rd_addr = w_grant0 ? c0_req_addr :
                      w_grant1 ? c1_req_addr : '0;

  assign w_cap_data = (rf_wr_en && (rf_wr_addr == rf_rd_addr)) ? rf_wr_data : rf_rd_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= 1'b1;
    end else if (w_grant0) begin
      r_last_grant <= 1'b0;
    end else if (w_grant1) begin
      r_last_grant <= 1'b1;
    end
  end

  reg_8x64b_rd_arb_rd_rsp_slot u_slot0 (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (c0_req_valid),
    .i_rsp_ready (c0_rsp_ready),
    .i_grant     (w_grant0),
    .i_cap_data  (w_cap_data),
    .o_eligible  (w_elig0),
    .o_rsp_valid (c0_rsp_valid),
    .o_rsp_data  (c0_rsp_data),
    .o_state     (w_state0)
  );

  reg_8x64b_rd_arb_rd_rsp_slot u_slot1 (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (c1_req_valid),
    .i_rsp_ready (c1_rsp_ready),
    .i_grant     (w_grant1),
    .i_cap_data  (w_cap_data),
    .o_eligible  (w_elig1),
    .o_rsp_valid (c1_rsp_valid),
    .o_rsp_data  (c1_rsp_data),
    .o_state     (w_state1)
  );

endmodule

// File: tb/tb_reg_8x64b_rd_arb.sv
// Directed bench for reg_8x64b_rd_arb: register-file model, per-client expected queues,
// and immediate-assertion checks on grants, read address, response valid and data.
module tb_reg_8x64b_rd_arb;

  logic        clk;
  logic        rst;
  logic        c0_req_valid;
  logic [2:0]  c0_req_addr;
  logic        c0_req_ready;
  logic        c0_rsp_valid;
  logic [63:0] c0_rsp_data;
  logic        c0_rsp_ready;
  logic        c1_req_valid;
  logic [2:0]  c1_req_addr;
  logic        c1_req_ready;
  logic        c1_rsp_valid;
  logic [63:0] c1_rsp_data;
  logic        c1_rsp_ready;
  logic [2:0]  rf_rd_addr;
  logic [63:0] rf_rd_data;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_addr;
  logic [63:0] rf_wr_data;

  logic [63:0] rf_mem [8];
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  logic        exp_full0;
  logic        exp_full1;
  logic [63:0] hold0;
  logic [63:0] hold1;
  int          tests;
  int          fails;

  reg_8x64b_rd_arb dut (
    .clk          (clk),
    .rst          (rst),
    .c0_req_valid (c0_req_valid),
    .c0_req_addr  (c0_req_addr),
    .c0_req_ready (c0_req_ready),
    .c0_rsp_valid (c0_rsp_valid),
    .c0_rsp_data  (c0_rsp_data),
    .c0_rsp_ready (c0_rsp_ready),
    .c1_req_valid (c1_req_valid),
    .c1_req_addr  (c1_req_addr),
    .c1_req_ready (c1_req_ready),
    .c1_rsp_valid (c1_rsp_valid),
    .c1_rsp_data  (c1_rsp_data),
    .c1_rsp_ready (c1_rsp_ready),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_data   (rf_rd_data),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: loaded while reset is low, written through the snooped port.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= 64'hDEAD_BEEF_0000_0000 | 64'(i);
    end else if (rf_wr_en) begin
      rf_mem[rf_wr_addr] <= rf_wr_data;
    end
  end
  assign rf_rd_data = rf_mem[rf_rd_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fwd(input logic [2:0] a);
    return (rf_wr_en && rf_wr_addr == a) ? rf_wr_data : rf_mem[a];
  endfunction

  // One clock cycle with the currently driven inputs and the expected grants.
  task automatic cycle(input string tag, input logic eg0, input logic eg1);
    logic [2:0] exp_addr;
    @(negedge clk);
    chk({tag, " c0_req_ready"}, 64'(c0_req_ready), 64'(eg0));
    chk({tag, " c1_req_ready"}, 64'(c1_req_ready), 64'(eg1));
    exp_addr = eg0 ? c0_req_addr : (eg1 ? c1_req_addr : 3'd0);
    chk({tag, " rf_rd_addr"}, 64'(rf_rd_addr), 64'(exp_addr));
    if (eg0) exp_q0.push_back(fwd(c0_req_addr));
    if (eg1) exp_q1.push_back(fwd(c1_req_addr));
    @(posedge clk);
    #1;
    if (eg0) exp_full0 = 1'b1; else if (c0_rsp_ready) exp_full0 = 1'b0;
    if (eg1) exp_full1 = 1'b1; else if (c1_rsp_ready) exp_full1 = 1'b0;
    if (eg0 && exp_q0.size() > 0) hold0 = exp_q0.pop_front();
    if (eg1 && exp_q1.size() > 0) hold1 = exp_q1.pop_front();
    chk({tag, " c0_rsp_valid"}, 64'(c0_rsp_valid), 64'(exp_full0));
    chk({tag, " c1_rsp_valid"}, 64'(c1_rsp_valid), 64'(exp_full1));
    if (exp_full0) chk({tag, " c0_rsp_data"}, c0_rsp_data, hold0);
    if (exp_full1) chk({tag, " c1_rsp_data"}, c1_rsp_data, hold1);
  endtask

  initial begin
    logic [2:0] n0;
    logic [2:0] n1;
    tests = 0; fails = 0;
    exp_full0 = 1'b0; exp_full1 = 1'b0; hold0 = '0; hold1 = '0;
    rst = 1'b0;
    c0_req_valid = 1'b0; c0_req_addr = '0; c0_rsp_ready = 1'b0;
    c1_req_valid = 1'b0; c1_req_addr = '0; c1_rsp_ready = 1'b0;
    rf_wr_en = 1'b0; rf_wr_addr = '0; rf_wr_data = '0;

    #1;
    chk("reset c0_rsp_valid", 64'(c0_rsp_valid), 64'd0);
    chk("reset c1_rsp_valid", 64'(c1_rsp_valid), 64'd0);
    chk("reset c0_rsp_data", c0_rsp_data, 64'd0);
    chk("reset c1_rsp_data", c1_rsp_data, 64'd0);
    chk("reset c0_req_ready", 64'(c0_req_ready), 64'd0);
    chk("reset rf_rd_addr", 64'(rf_rd_addr), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Single read from client 0
    c0_req_valid = 1'b1; c0_req_addr = 3'd5; c0_rsp_ready = 1'b1;
    cycle("c0_single", 1'b1, 1'b0);
    chk("c0_single literal", c0_rsp_data, 64'hDEAD_BEEF_0000_0005);

    // Client 1 alone while client 0 drains
    c0_req_valid = 1'b0;
    c1_req_valid = 1'b1; c1_req_addr = 3'd1; c1_rsp_ready = 1'b1;
    cycle("c1_single", 1'b0, 1'b1);

    // Both contend every cycle: strict alternation starting with client 0
    c0_req_valid = 1'b1; n0 = 3'd0; n1 = 3'd7;
    for (int i = 0; i < 4; i++) begin
      c0_req_addr = n0; c1_req_addr = n1;
      cycle("alternate", (i % 2) == 0, (i % 2) == 1);
      if ((i % 2) == 0) n0 = n0 + 3'd1; else n1 = n1 - 3'd1;
    end

    // Client 0 fills and stalls; client 1 takes every grant meanwhile
    c0_rsp_ready = 1'b0; c0_req_addr = 3'd4; c1_req_addr = 3'd2;
    cycle("c0_fill", 1'b1, 1'b0);
    chk("c0_fill literal", c0_rsp_data, 64'hDEAD_BEEF_0000_0004);
    c0_req_addr = 3'd6;
    rf_wr_en = 1'b1; rf_wr_addr = 3'd4; rf_wr_data = 64'hFFFF;
    cycle("c0_stall_wr", 1'b0, 1'b1);
    rf_wr_en = 1'b0; c1_req_addr = 3'd3;
    cycle("c0_stall", 1'b0, 1'b1);
    chk("snapshot held", c0_rsp_data, 64'hDEAD_BEEF_0000_0004);
    c0_rsp_ready = 1'b1;
    cycle("c0_b2b", 1'b1, 1'b0);

    // Write snooping on client 1
    c0_req_valid = 1'b0;
    c1_req_addr = 3'd2; rf_wr_en = 1'b1; rf_wr_addr = 3'd3; rf_wr_data = 64'h5678;
    cycle("fwd_other", 1'b0, 1'b1);
    chk("fwd_other literal", c1_rsp_data, 64'hDEAD_BEEF_0000_0002);
    rf_wr_addr = 3'd2; rf_wr_data = 64'h1234;
    cycle("fwd_same", 1'b0, 1'b1);
    chk("fwd_same literal", c1_rsp_data, 64'h1234);
    rf_wr_en = 1'b0;

    // Fill both slots, then reset mid-operation
    c0_req_valid = 1'b1; c0_req_addr = 3'd1; c0_rsp_ready = 1'b0;
    c1_req_addr = 3'd3; c1_rsp_ready = 1'b1;
    cycle("fill0", 1'b1, 1'b0);
    c1_rsp_ready = 1'b0;
    cycle("fill1", 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    exp_full0 = 1'b0; exp_full1 = 1'b0;
    exp_q0.delete(); exp_q1.delete();
    chk("midreset c0_rsp_valid", 64'(c0_rsp_valid), 64'd0);
    chk("midreset c1_rsp_valid", 64'(c1_rsp_valid), 64'd0);
    c0_req_valid = 1'b0; c1_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // First contention after reset goes to client 0
    c0_req_valid = 1'b1; c0_req_addr = 3'd5; c0_rsp_ready = 1'b1;
    c1_req_valid = 1'b1; c1_req_addr = 3'd0; c1_rsp_ready = 1'b1;
    cycle("post_reset0", 1'b1, 1'b0);
    c0_req_valid = 1'b0;
    cycle("post_reset1", 1'b0, 1'b1);
    c1_req_valid = 1'b0;
    cycle("idle", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
